pid_pwm_out: RTL
================

# pid_pwm_out

Output stage on the consumer side of the PID controller's multiplexed result bus. It samples each PID channel's signed motor-power word when the controller strobes `ce` and stores it per address. It converts each word to sign/magnitude and drives one glitch-free PWM output plus one direction output per channel. New duty values are applied only at PWM period boundaries.

## Interface
Parameters:
- `aw`, 1: address width; `an = 1<<aw` channels
- `ow`, 12: width of signed input word; PWM resolution `pw = ow-1` bits
- `dt`, 16: dead-time in clocks after a direction change (used only with the dead-time macro)
- `tw`, 20: watchdog width; a channel times out after `2^tw` clocks without a capture

Ports:
- `clk_pid`  in  1  system clock; all logic on its rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `ce`  in  1  result-valid strobe from the PID; held high for several clocks per channel
- `a`  in  aw  channel address; stable while `ce` is high
- `m_k`  in  ow  signed motor power for channel `a`
- `pwm_out`  out  an  PWM per channel
- `dir_out`  out  an  direction per channel; 1 = negative
- `period_tick`  out  1  one-clock pulse on the last count of each PWM period

## Operation
- **Capture.** `ce` is registered as `ce_d`. A capture fires on the rising edge of `ce` (`ce & ~ce_d`) and writes `m_k` to `shadow[a]`. Only one capture happens per `ce` high interval. While `ce` is low, changes on `a` or `m_k` are ignored.
- **Conversion at capture.**
  - `sdir = m_k[ow-1]`.
  - `smag = |m_k|`, saturated to `2^pw-1`. So `-2^(ow-1)` maps to `2^pw-1`.
- **PWM counter.**
  - `cnt` is `pw` bits wide, free-running, and shared by all channels. It wraps from `2^pw-1` to 0.
  - `period_tick = (cnt == 2^pw-1)`.
- **Period-boundary transfer.** On a `period_tick` cycle, each channel copies `shadow` into its `active` mag/dir.
  - If a capture and the transfer happen in the same cycle, the transfer takes the pre-capture shadow value. The new value applies one period later.
- **Output.**
  - `pwm_out[i] = (cnt < active_mag[i])`, registered, so `pwm_out` lags `cnt` by one clock.
  - `dir_out[i] = active_dir[i]`, registered.
  - Magnitude 0 gives a constant low output. Magnitude `2^pw-1` gives `2^pw-1` high clocks out of `2^pw`.
- **Watchdog.**
  - Each channel has a `tw`-bit counter that clears on a capture to that channel and otherwise increments, saturating.
  - On reaching `2^tw-1`, the channel's `shadow` is forced to mag 0 / dir 0. The forced value takes effect at the next boundary.
  - The next capture clears the timeout.
- **Reset.** Asserting `reset_n` low clears `cnt`, `ce_d`, all shadow/active registers and watchdogs, `pwm_out`, `dir_out` and `period_tick` to 0 immediately. This applies even mid-period. After deassertion, operation restarts at `cnt = 0`.

## Timing
- Capture is written 1 clock after the `ce` rising edge is sampled.
- Capture-to-output latency is at most `2^pw + 2` clocks: wait for the boundary, then transfer, then the output register.
- Address `a` and `m_k` must be valid in the cycle `ce` rises. The PID holds them for many clocks, so there is no further handshake and no back-pressure.

## Configuration
- `PID_PWM_DEADTIME_EN` defined:
  - When a transfer changes a channel's `active_dir`, that channel's `pwm_out` is forced low for the first `dt` clocks of the new period, i.e. while `cnt < dt`.
  - `dir_out` switches at the boundary as usual.
  - Transfers that do not change direction are unaffected.
- Macro undefined: there is no dead-time logic, and `dt` is ignored.

## Structure
- Package `pid_pwm_pkg`:
  - width helpers (`pw` from `ow`)
  - `abs_sat` function (signed `ow` to unsigned `pw` magnitude, with saturation)
  - channel state struct {mag, dir, wdog}
- Sub-module `pid_pwm_channel`, one instance per channel via generate. It holds the shadow/active registers, watchdog, dead-time and output register for one channel. The top level holds the `ce` edge detect, address decode and shared `cnt`.

## Test plan
- **Reset:** hold `reset_n` low for 5 clocks, then release with `ce = 0` -> `pwm_out = 0`, `dir_out = 0`, `period_tick` first pulses 2047 clocks after release (`ow = 12`).
- **Positive capture:** `a = 0`, `m_k = +512`, `ce` high for 7 clocks -> exactly one capture; after the next boundary `pwm_out[0]` is high 512 of every 2048 clocks, `dir_out[0] = 0`, and channel 1 is unchanged.
- **Saturation:** `a = 1`, `m_k = -2048` -> `dir_out[1] = 1`, `pwm_out[1]` high 2047 of 2048 clocks.
- **Boundary collision:** capture +100 in the same cycle as `period_tick` -> the following period uses the old value, and the period after that is high for 100 clocks.
- **Dead-time (`PID_PWM_DEADTIME_EN`, `dt = 16`):** +100 then -100 on channel 0 -> `dir_out[0]` flips at the boundary; the first period after the flip is high for 84 clocks, later periods for 100.
- **Watchdog (`tw = 12`):** capture +1000, then no `ce` for 4096 clocks -> after the next boundary `pwm_out[0]` stays low; a new capture of +1000 restores 1000/2048.

Source files
------------

// File: rtl/pid_pwm_pkg.sv
// Shared helpers for the PID PWM output stage: width derivation, signed-to-
// magnitude conversion with saturation, and the per-channel state record.
package pid_pwm_pkg;

    // Working width for the magnitude arithmetic; wide enough for any ow used.
    localparam int CALC_W = 32;

    // Default configuration, also used to size the reference state record.
    localparam int DEF_OW = 12;
    localparam int DEF_PW = DEF_OW - 1;
    localparam int DEF_TW = 20;

    // PWM resolution follows from the signed word width (sign bit dropped).
    function automatic int pw_of(input int ow);
        return ow - 1;
    endfunction

    // |v| clipped to 2^pw-1, so the most negative input still fits in pw bits.
    function automatic logic [CALC_W-1:0] abs_sat(input logic signed [CALC_W-1:0] v,
                                                  input int pw);
        logic [CALC_W-1:0] mag;
        logic [CALC_W-1:0] lim;
        mag = v[CALC_W-1] ? $unsigned(-v) : $unsigned(v);
        lim = (CALC_W'(1) << pw) - CALC_W'(1);
        return (mag > lim) ? lim : mag;
    endfunction

    // Per-channel state at the default configuration.
    typedef struct packed {
        logic [DEF_PW-1:0] mag;
        logic              dir;
        logic [DEF_TW-1:0] wdog;
    } chan_state_t;

endpackage

// File: rtl/pid_pwm_out_channel.sv
// One PWM output channel: shadow/active duty registers, capture watchdog,
// optional dead-time after a direction flip (PID_PWM_DEADTIME_EN), and the
// registered pwm/dir outputs.
module pid_pwm_channel
    import pid_pwm_pkg::*;
#(
    parameter int pw = 11,
    parameter int tw = 20,
    parameter int dt = 16
) (
    input  logic          clk_pid,
    input  logic          reset_n,
    input  logic [pw-1:0] cnt,
    input  logic          period_tick,
    input  logic          cap,
    input  logic [pw-1:0] cap_mag,
    input  logic          cap_dir,
    output logic          pwm_out,
    output logic          dir_out
);

    localparam logic [tw-1:0] WD_MAX = {tw{1'b1}};

    logic [pw-1:0] shadow_mag_q, shadow_mag_d;
    logic          shadow_dir_q, shadow_dir_d;
    logic [pw-1:0] active_mag_q, active_mag_d;
    logic          active_dir_q, active_dir_d;
    logic [tw-1:0] wdog_q, wdog_d;
    logic          pwm_q, pwm_d;
    logic          dir_q, dir_d;
`ifdef PID_PWM_DEADTIME_EN
    logic          hold_q, hold_d;
`endif

    // Next-state: capture/watchdog into shadow, boundary transfer, output compare.
    always_comb begin
        wdog_d       = wdog_q;
        shadow_mag_d = shadow_mag_q;
        shadow_dir_d = shadow_dir_q;
        active_mag_d = active_mag_q;
        active_dir_d = active_dir_q;

        if (cap) begin
            wdog_d       = '0;
            shadow_mag_d = cap_mag;
            shadow_dir_d = cap_dir;
        end else begin
            if (wdog_q != WD_MAX) begin
                wdog_d = wdog_q + tw'(1);
            end else begin
                shadow_mag_d = '0;
                shadow_dir_d = 1'b0;
            end
        end

        // Transfer reads the registered shadow, so a same-cycle capture lands a period later.
        if (period_tick) begin
            active_mag_d = shadow_mag_q;
            active_dir_d = shadow_dir_q;
        end

        pwm_d = (cnt < active_mag_q);
        dir_d = active_dir_q;

`ifdef PID_PWM_DEADTIME_EN
        hold_d = hold_q;
        if (period_tick) begin
            hold_d = (shadow_dir_q != active_dir_q);
        end
        if (hold_q && ({{(32-pw){1'b0}}, cnt} < 32'(dt))) begin
            pwm_d = 1'b0;
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk_pid or negedge reset_n) begin
        if (!reset_n) begin
            shadow_mag_q <= '0;
            shadow_dir_q <= 1'b0;
            active_mag_q <= '0;
            active_dir_q <= 1'b0;
            wdog_q       <= '0;
            pwm_q        <= 1'b0;
            dir_q        <= 1'b0;
`ifdef PID_PWM_DEADTIME_EN
            hold_q       <= 1'b0;
`endif
        end else begin
            shadow_mag_q <= shadow_mag_d;
            shadow_dir_q <= shadow_dir_d;
            active_mag_q <= active_mag_d;
            active_dir_q <= active_dir_d;
            wdog_q       <= wdog_d;
            pwm_q        <= pwm_d;
            dir_q        <= dir_d;
`ifdef PID_PWM_DEADTIME_EN
            hold_q       <= hold_d;
`endif
        end
    end

    assign pwm_out = pwm_q;
    assign dir_out = dir_q;

endmodule

// File: rtl/pid_pwm_out.sv
// PID result-bus consumer: detects the ce rising edge, converts the signed
// word to sign/magnitude, decodes the address and runs the shared PWM
// counter. Optional dead-time is enabled with PID_PWM_DEADTIME_EN.
module pid_pwm_out
    import pid_pwm_pkg::*;
#(
    parameter int aw = 1,
    parameter int ow = 12,
    parameter int dt = 16,
    parameter int tw = 20,
    localparam int an = 1 << aw
) (
    input  logic          clk_pid,
    input  logic          reset_n,
    input  logic          ce,
    input  logic [aw-1:0] a,
    input  logic [ow-1:0] m_k,
    output logic [an-1:0] pwm_out,
    output logic [an-1:0] dir_out,
    output logic          period_tick
);

    localparam int pw = pw_of(ow);

    logic                     ce_d_q, ce_d_d;
    logic [pw-1:0]            cnt_q, cnt_d;
    logic                     capture;
    logic signed [CALC_W-1:0] m_ext;
    logic [CALC_W-1:0]        mag_full;
    logic [pw-1:0]            cap_mag;
    logic                     cap_dir;

    // Edge detect, counter advance and word conversion shared by all channels.
    always_comb begin
        ce_d_d   = ce;
        cnt_d    = cnt_q + pw'(1);
        capture  = ce & ~ce_d_q;
        m_ext    = {{(CALC_W-ow){m_k[ow-1]}}, m_k};
        mag_full = abs_sat(m_ext, pw);
        cap_mag  = mag_full[pw-1:0];
        cap_dir  = m_k[ow-1];
    end

    // ce history and free-running PWM counter.
    always_ff @(posedge clk_pid or negedge reset_n) begin
        if (!reset_n) begin
            ce_d_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            ce_d_q <= ce_d_d;
            cnt_q  <= cnt_d;
        end
    end

    assign period_tick = (cnt_q == {pw{1'b1}});

    for (genvar i = 0; i < an; i++) begin : g_chan
        pid_pwm_channel #(
            .pw (pw),
            .tw (tw),
            .dt (dt)
        ) u_chan (
            .clk_pid     (clk_pid),
            .reset_n     (reset_n),
            .cnt         (cnt_q),
            .period_tick (period_tick),
            .cap         (capture && (a == aw'(i))),
            .cap_mag     (cap_mag),
            .cap_dir     (cap_dir),
            .pwm_out     (pwm_out[i]),
            .dir_out     (dir_out[i])
        );
    end

endmodule
